// File: rtl/addition_align_shifter.sv
// Stage-2 mantissa alignment: iterative right shift of the smaller-exponent mantissa with G/R/S.
// Build option ALIGN_STICKY_EN: when defined, shifted-out bits are ORed into the sticky bit.
module addition_align_shifter #(
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 24,
    parameter int SHIFT_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [MANT_WIDTH-1:0]   mant_a_in,
    input  logic [MANT_WIDTH-1:0]   mant_b_in,
    input  logic                    swap_sel_in,
    input  logic [EXPO_WIDTH-1:0]   rshift_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [MANT_WIDTH+2:0]   big_mant_out,
    output logic [MANT_WIDTH+2:0]   aligned_mant_out,
    output logic                    busy_out
);
    localparam int W  = MANT_WIDTH + 3;
    localparam int KW = (SHIFT_STEP > 1) ? $clog2(SHIFT_STEP) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [EXPO_WIDTH-1:0]   rem_reg, rem_next;
    logic [W-1:0]            aligned_reg, aligned_next;
    logic [W-1:0]            big_reg, big_next;

    logic                    accept;
    logic                    zero_shift;
    logic                    sat_shift;
    logic                    last_step;
    logic [MANT_WIDTH-1:0]   shift_op;
    logic [MANT_WIDTH-1:0]   other_op;
    logic [W-1:0]            sat_value;
    logic [W-1:0]            step_cand [SHIFT_STEP];
    logic [KW-1:0]           step_sel;

    assign accept     = valid_in && (state_reg == IDLE);
    assign shift_op   = swap_sel_in ? mant_b_in : mant_a_in;
    assign other_op   = swap_sel_in ? mant_a_in : mant_b_in;
    assign zero_shift = (rshift_in == '0);
    assign sat_shift  = 32'(rshift_in) >= 32'(W);
    assign last_step  = 32'(rem_reg) <= 32'(SHIFT_STEP);

    // SHIFT_STEP is a power of two, so rem==SHIFT_STEP wraps to index SHIFT_STEP-1 here.
    assign step_sel = last_step ? KW'(rem_reg[KW-1:0] - KW'(1)) : KW'(SHIFT_STEP - 1);

`ifdef ALIGN_STICKY_EN
    assign sat_value = W'(|shift_op);
`else
    assign sat_value = '0;
`endif

    // One candidate per possible shift amount 1..SHIFT_STEP; the FSM picks one per cycle.
    generate
        for (genvar gi = 0; gi < SHIFT_STEP; gi++) begin : g_step
`ifdef ALIGN_STICKY_EN
            assign step_cand[gi] = (aligned_reg >> (gi + 1)) | W'(|aligned_reg[gi:0]);
`else
            assign step_cand[gi] = aligned_reg >> (gi + 1);
`endif
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        aligned_next = aligned_reg;
        big_next     = big_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    big_next = {other_op, 3'b000};
                    if (zero_shift) begin
                        aligned_next = {shift_op, 3'b000};
                        rem_next     = '0;
                        state_next   = DONE;
                    end else if (sat_shift) begin
                        aligned_next = sat_value;
                        rem_next     = '0;
                        state_next   = DONE;
                    end else begin
                        aligned_next = {shift_op, 3'b000};
                        rem_next     = rshift_in;
                        state_next   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                aligned_next = step_cand[step_sel];
                if (last_step) begin
                    rem_next   = '0;
                    state_next = DONE;
                end else begin
                    rem_next = rem_reg - EXPO_WIDTH'(SHIFT_STEP);
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg     <= '0;
            aligned_reg <= '0;
            big_reg     <= '0;
        end else begin
            rem_reg     <= rem_next;
            aligned_reg <= aligned_next;
            big_reg     <= big_next;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        ready_out = (state_reg == IDLE);
        valid_out = (state_reg == DONE);
        busy_out  = (state_reg == SHIFT) || (state_reg == DONE);
    end

    assign big_mant_out     = big_reg;
    assign aligned_mant_out = aligned_reg;

endmodule

// File: tb/tb_addition_align_shifter.sv
// Scoreboard bench for addition_align_shifter: directed cases, backpressure, mid-shift reset, random mix.
module tb_addition_align_shifter;
    localparam int EW   = 8;
    localparam int MW   = 24;
    localparam int STEP = 4;
    localparam int W    = MW + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [MW-1:0] mant_a_in;
    logic [MW-1:0] mant_b_in;
    logic          swap_sel_in;
    logic [EW-1:0] rshift_in;
    logic          valid_out;
    logic          ready_in;
    logic [W-1:0]  big_mant_out;
    logic [W-1:0]  aligned_mant_out;
    logic          busy_out;

    typedef struct {
        logic [W-1:0] big;
        logic [W-1:0] aligned;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   txn_num  = 0;
    bit   vseen    = 1'b0;

    addition_align_shifter #(.EXPO_WIDTH(EW), .MANT_WIDTH(MW), .SHIFT_STEP(STEP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .mant_a_in        (mant_a_in),
        .mant_b_in        (mant_b_in),
        .swap_sel_in      (swap_sel_in),
        .rshift_in        (rshift_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .big_mant_out     (big_mant_out),
        .aligned_mant_out (aligned_mant_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Closed-form reference: full shift at once, sticky is the OR of every bit dropped.
    function automatic logic [W-1:0] model(input logic [MW-1:0] op, input int r);
        logic [W-1:0] x;
        logic [W-1:0] res;
        x = {op, 3'b000};
        if (r == 0) return x;
        if (r >= W) begin
`ifdef ALIGN_STICKY_EN
            return W'(|op);
`else
            return '0;
`endif
        end
        res = x >> r;
`ifdef ALIGN_STICKY_EN
        begin
            logic [W-1:0] mask;
            mask   = ~({W{1'b1}} << r);
            res[0] = res[0] | (|(x & mask));
        end
`endif
        return res;
    endfunction

    function automatic int model_lat(input int r);
        if (r == 0 || r >= W) return 1;
        return 1 + (r + STEP - 1) / STEP;
    endfunction

    // Monitor: latency on the rising valid, data on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            vseen = 1'b0;
        end else begin
            if (valid_out && !vseen) begin
                vseen = 1'b1;
                if (sb_q.size() == 0) check_val("spurious_valid", 64'(valid_out), 64'd0);
                else check_val("latency", 64'(cyc - sb_q[0].acc_cyc + 1), 64'(sb_q[0].lat));
            end
            if (valid_out && ready_in && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_val("big_mant", 64'(big_mant_out), 64'(mon_e.big));
                check_val("aligned_mant", 64'(aligned_mant_out), 64'(mon_e.aligned));
                txn_num++;
                $display("txn %0d big=%h aligned=%h exp_aligned=%h", txn_num,
                         big_mant_out, aligned_mant_out, mon_e.aligned);
                vseen = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic sel, input int r);
        int   guard;
        exp_t e;
        logic [31:0] r32;
        guard = 0;
        while (!ready_out && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready_out) begin
            check_val("send_timeout", 64'(ready_out), 64'd1);
            return;
        end
        r32         = r;
        mant_a_in   = a;
        mant_b_in   = b;
        swap_sel_in = sel;
        rshift_in   = r32[EW-1:0];
        valid_in    = 1'b1;
        @(posedge clk); #1;
        e.big     = sel ? {a, 3'b000} : {b, 3'b000};
        e.aligned = model(sel ? b : a, r);
        e.lat     = model_lat(r);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        check_val("drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},   64'(ready_out),        64'd1);
        check_val({tag, "_valid"},   64'(valid_out),        64'd0);
        check_val({tag, "_busy"},    64'(busy_out),         64'd0);
        check_val({tag, "_big"},     64'(big_mant_out),     64'd0);
        check_val({tag, "_aligned"}, 64'(aligned_mant_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int r;
        rst_n       = 1'b0;
        valid_in    = 1'b0;
        ready_in    = 1'b1;
        mant_a_in   = '0;
        mant_b_in   = '0;
        swap_sel_in = 1'b0;
        rshift_in   = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(24'hC00000, 24'h800001, 1'b1, 5);  drain();
        send(24'hABCDEF, 24'h000000, 1'b0, 0);  drain();
        send(24'h000000, 24'h000001, 1'b1, 30); drain();
        send(24'h000000, 24'hFFFFFF, 1'b1, 8);  drain();
        send(24'h800000, 24'hFFFFFF, 1'b1, 27); drain();
        send(24'h7FFFFF, 24'h800000, 1'b0, 26); drain();

        // Backpressure: hold DONE for 5 cycles, poke valid_in, then release.
        ready_in = 1'b0;
        send(24'h123456, 24'h654321, 1'b0, 9);
        g = 0;
        while (!valid_out && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check_val("bp_valid_rise", 64'(valid_out), 64'd1);
        mant_a_in = 24'hFFFFFF;
        rshift_in = '0;
        valid_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_valid_hold", 64'(valid_out), 64'd1);
            check_val("bp_ready_low",  64'(ready_out), 64'd0);
            check_val("bp_aligned_hold", 64'(aligned_mant_out), 64'(sb_q[0].aligned));
            check_val("bp_big_hold",     64'(big_mant_out),     64'(sb_q[0].big));
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_ready", 64'(ready_out), 64'd1);
        check_val("bp_release_valid", 64'(valid_out), 64'd0);
        check_val("bp_queue_empty",   64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
        check_val("bp_no_extra_accept", 64'(busy_out), 64'd0);

        // Reset in the middle of a long shift.
        send(24'h000000, 24'h0ABCDE, 1'b1, 20);
        @(posedge clk); #1;
        check_val("mid_busy", 64'(busy_out), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(24'h5A5A5A, 24'h00F00F, 1'b1, 3); drain();

        // Random mix over zero, partial, exact-multiple and saturating shifts.
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 35));
            send(MW'($urandom), MW'($urandom), 1'($urandom_range(0, 1)), r);
            drain();
        end

        check_val("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
